cp0_int_ctrl: RTL

Coprocessor-0 interrupt controller at the consumer end of the EX/DM pipeline register. It acts on the CP0 control fields carried to the DM stage: the interrupt-entry marker, the IE/EPC write enables and the CP0 op. It synchronises external interrupt lines and latches them as pending. It raises a prioritised interrupt request with a vector to the fetch/hazard unit, and owns the Status, Cause and EPC registers, including MFC0/MTC0/ERET handling.

---
 rtl/cp0_int_ctrl_if.sv | 49 ++++
 rtl/cp0_int_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cp0_int_ctrl_if.sv
// DM-stage CP0 control bundle between the pipeline and the CP0 interrupt controller.
// The pipeline side drives the DM fields and consumes the request, vector and register outputs.
interface cp0_int_ctrl_if;
    logic        dm_en;
    logic        inting_dm;
    logic        w_en_ie_dm;
    logic        w_en_epc_dm;
    logic [1:0]  op_cp0_dm;
    logic [1:0]  cp0_sel_dm;
    logic [31:0] cp0_wdata_dm;
    logic [31:0] pc_4_dm;
    logic        int_req;
    logic [31:0] int_vector;
    logic [31:0] epc;
    logic        ie;
    logic [31:0] cp0_rdata;

    modport master (
        output dm_en,
        output inting_dm,
        output w_en_ie_dm,
        output w_en_epc_dm,
        output op_cp0_dm,
        output cp0_sel_dm,
        output cp0_wdata_dm,
        output pc_4_dm,
        input  int_req,
        input  int_vector,
        input  epc,
        input  ie,
        input  cp0_rdata
    );

    modport slave (
        input  dm_en,
        input  inting_dm,
        input  w_en_ie_dm,
        input  w_en_epc_dm,
        input  op_cp0_dm,
        input  cp0_sel_dm,
        input  cp0_wdata_dm,
        input  pc_4_dm,
        output int_req,
        output int_vector,
        output epc,
        output ie,
        output cp0_rdata
    );
endinterface

// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt controller: source synchronisation, pending latch, prioritised request and Status/Cause/EPC.
// Optional macro CP0_INT_MASK_EN adds a writable per-source IM mask in Status[8+N_SRC-1:8].
module cp0_int_ctrl #(
    parameter int          N_SRC      = 3,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0800,
    parameter int          VEC_STRIDE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] int_src,
    cp0_int_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [N_SRC-1:0] sync1;
    logic [N_SRC-1:0] sync2;
    logic [N_SRC-1:0] edge_d;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] pending_next;
    logic [N_SRC-1:0] clear_mask;
    logic [N_SRC-1:0] im;
    logic [N_SRC-1:0] enabled;

    logic [2:0]  sel;
    logic [2:0]  lowest_idx;
    logic        sel_load;
    logic        any_enabled;
    logic [4:0]  code;
    logic        ie_r;
    logic [31:0] epc_r;
    logic [31:0] rdata;

    logic entry;
    logic eret;
    logic mtc0_status;
    logic mtc0_epc;

    assign entry       = bus.dm_en && bus.inting_dm;
    assign eret        = bus.dm_en && (bus.op_cp0_dm == 2'd3);
    assign mtc0_status = bus.dm_en && (bus.op_cp0_dm == 2'd2) && (bus.cp0_sel_dm == 2'd0) && !entry;
    assign mtc0_epc    = bus.dm_en && (bus.op_cp0_dm == 2'd2) && (bus.cp0_sel_dm == 2'd2);

    // Two flops for metastability, a third to find the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            edge_d <= '0;
        end else begin
            sync1  <= int_src;
            sync2  <= sync1;
            edge_d <= sync2;
        end
    end

    assign rise = sync2 & ~edge_d;

    always_comb begin
        clear_mask = '0;
        for (int i = 0; i < N_SRC; i++) begin
            clear_mask[i] = entry && (sel == 3'(i));
        end
    end

    // A new edge arriving on the same cycle as its clear must not be lost.
    assign pending_next = (pending & ~clear_mask) | rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

`ifdef CP0_INT_MASK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            im <= '0;
        end else if (mtc0_status) begin
            im <= bus.cp0_wdata_dm[8 +: N_SRC];
        end
    end

    assign enabled = pending & im;
`else
    assign im      = '0;
    assign enabled = pending;
`endif

    always_comb begin
        any_enabled = |enabled;
        lowest_idx  = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (enabled[i]) begin
                lowest_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Arbitration happens only in IDLE, so a request in flight never changes source.
    always_comb begin
        state_next = state;
        sel_load   = 1'b0;
        case (state)
            IDLE: begin
                if (ie_r && any_enabled) begin
                    state_next = REQ;
                    sel_load   = 1'b1;
                end
            end
            REQ: begin
                if (entry) begin
                    state_next = SERVICE;
                end
            end
            SERVICE: begin
                if (eret) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel <= 3'd0;
        end else if (sel_load) begin
            sel <= lowest_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code <= 5'd0;
        end else if (entry) begin
            code <= {2'b00, sel};
        end
    end

    // Entry takes precedence over ERET and MTC0 for the IE bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie_r <= 1'b0;
        end else if (entry) begin
            if (bus.w_en_ie_dm) begin
                ie_r <= 1'b0;
            end
        end else if (eret) begin
            ie_r <= 1'b1;
        end else if (mtc0_status) begin
            ie_r <= bus.cp0_wdata_dm[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epc_r <= 32'd0;
        end else if (entry && bus.w_en_epc_dm) begin
            epc_r <= bus.pc_4_dm;
        end else if (mtc0_epc) begin
            epc_r <= bus.cp0_wdata_dm;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (bus.cp0_sel_dm)
            2'd0: begin
                rdata[0]          = ie_r;
                rdata[8 +: N_SRC] = im;
            end
            2'd1: begin
                rdata[8 +: N_SRC] = pending;
                rdata[6:2]        = code;
            end
            2'd2: begin
                rdata = epc_r;
            end
            default: begin
                rdata = 32'd0;
            end
        endcase
    end

    assign bus.int_req    = (state == REQ);
    assign bus.int_vector = VEC_BASE + ({29'd0, sel} * 32'(VEC_STRIDE));
    assign bus.epc        = epc_r;
    assign bus.ie         = ie_r;
    assign bus.cp0_rdata  = rdata;

endmodule
